// File: rtl/ic_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ic_read_arbiter
//  Description : Round-robin arbiter sharing one DDR instruction-read port
//                (valid/addr/ack/data) between NUM_REQ instruction-cache
//                read requesters. One transaction outstanding at a time.
//                Optional watchdog enabled by defining ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ic_read_arbiter #(
  parameter int  NUM_REQ     = 2,
  parameter int  ADDR_W      = 32,
  parameter int  DATA_W      = 128,
  parameter int  TIMEOUT_CYC = 1024,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic                      dma_valid_o,
  output logic [ADDR_W-1:0]         dma_addr_o,
  input  logic                      dma_ack_i,
  input  logic [DATA_W-1:0]         dma_data_i,
  output logic [GW-1:0]             grant_id_o,
  output logic                      busy_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  req_ack_q;
  logic [DATA_W-1:0]   req_data_q;
  logic                dma_valid_q;
  logic [ADDR_W-1:0]   dma_addr_q;
  logic [GW-1:0]       grant_id_q;
  logic [GW-1:0]       last_grant_q;

  logic [GW-1:0]       win_id_d;
  logic                win_vld_d;
  logic [GW-1:0]       cand_d;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

  // Reject parameter values outside the supported range at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("ic_read_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  // Unpack the flattened address bus into one entry per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr_unpack
    assign addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
  end

  // Round-robin search starting just after the last grant; the last grantee
  // is examined last, so it only wins again when nobody else is asking.
  always_comb begin
    win_id_d  = '0;
    win_vld_d = 1'b0;
    cand_d    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_d = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_vld_d && req_valid_i[cand_d]) begin
        win_vld_d = 1'b1;
        win_id_d  = cand_d;
      end
    end
  end

  // Transaction FSM with registered downstream request and upstream response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ack_q    <= '0;
      req_data_q   <= '0;
      dma_valid_q  <= 1'b0;
      dma_addr_q   <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            grant_id_q  <= win_id_d;
            dma_addr_q  <= addr_arr[win_id_d];
            dma_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // No abort path: the grantee is answered even if it withdrew.
          if (dma_ack_i) begin
            req_data_q  <= dma_data_i;
            req_ack_q   <= NUM_REQ'(1) << grant_id_q;
            dma_valid_q <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          req_ack_q    <= '0;
          last_grant_q <= grant_id_q;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_err_q;

  // Watchdog: counts REQ cycles without an ack; the error flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else if (state_q == IDLE && win_vld_d) begin
      cnt_q <= '0;
    end else if (state_q == REQ && !dma_ack_i) begin
      if (cnt_q < CW'(TIMEOUT_CYC)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err_o = timeout_err_q;
`endif

  assign req_ack_o   = req_ack_q;
  assign req_data_o  = req_data_q;
  assign dma_valid_o = dma_valid_q;
  assign dma_addr_o  = dma_addr_q;
  assign grant_id_o  = grant_id_q;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ic_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ic_read_arbiter
//  Description : Scoreboard bench for ic_read_arbiter. Stimulus pushes the
//                expected grant and ack records; a negedge monitor pops and
//                compares them as the DUT presents grants and acks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ic_read_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 128;
  localparam int TO_CYC  = 16;
  localparam int GW      = 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         req_data;
  logic                      dma_valid;
  logic [ADDR_W-1:0]         dma_addr;
  logic                      dma_ack = 1'b0;
  logic [DATA_W-1:0]         dma_data = '0;
  logic [GW-1:0]             grant_id;
  logic                      busy;
`ifdef ARB_TIMEOUT_EN
  logic                      timeout_err;
`endif

  always #5 clk = ~clk;

  ic_read_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ack_o   (req_ack),
    .req_data_o  (req_data),
    .dma_valid_o (dma_valid),
    .dma_addr_o  (dma_addr),
    .dma_ack_i   (dma_ack),
    .dma_data_i  (dma_data),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_err_o (timeout_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [GW-1:0]      exp_gid_q  [$];
  logic [ADDR_W-1:0]  exp_addr_q [$];
  logic [NUM_REQ-1:0] exp_ack_q  [$];
  logic [DATA_W-1:0]  exp_data_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_grant(input logic [GW-1:0] id, input logic [ADDR_W-1:0] a);
    exp_gid_q.push_back(id);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_ack(input logic [NUM_REQ-1:0] ack, input logic [DATA_W-1:0] d);
    exp_ack_q.push_back(ack);
    exp_data_q.push_back(d);
  endtask

  // Downstream responder: wait for a request, delay, pulse ack, optionally
  // let the acked requesters drop their request lines.
  task automatic serve(input logic [DATA_W-1:0] d, input int dly, input logic [NUM_REQ-1:0] drop);
    int w;
    w = 0;
    while (!dma_valid && w < 50) begin
      tick(1);
      w++;
    end
    if (!dma_valid) begin
      chk("dma_valid_wait", 128'(dma_valid), 128'(1));
      return;
    end
    tick(dly);
    dma_ack  = 1'b1;
    dma_data = d;
    tick(1);
    dma_ack  = 1'b0;
    dma_data = '0;
    req_valid = req_valid & ~drop;
  endtask

  // Monitor: new grant -> check grant record; ack -> check ack record.
  logic               prev_dv  = 1'b0;
  logic [NUM_REQ-1:0] prev_ack = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv  = 1'b0;
      prev_ack = '0;
    end else begin
      if (dma_valid && !prev_dv) begin
        if (exp_gid_q.size() == 0) begin
          chk("unexpected_grant", 128'(dma_valid), 128'(0));
        end else begin
          chk("grant_id", 128'(grant_id), 128'(exp_gid_q.pop_front()));
          chk("dma_addr_at_grant", 128'(dma_addr), 128'(exp_addr_q.pop_front()));
        end
      end
      if (req_ack != '0) begin
        chk("ack_single_cycle", 128'(prev_ack), 128'(0));
        if (exp_ack_q.size() == 0) begin
          chk("unexpected_ack", 128'(req_ack), 128'(0));
        end else begin
          chk("req_ack", 128'(req_ack), 128'(exp_ack_q.pop_front()));
          chk("req_data", req_data, exp_data_q.pop_front());
        end
      end
      prev_dv  = dma_valid;
      prev_ack = req_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(3);
    chk("rst_req_ack",   128'(req_ack),   128'(0));
    chk("rst_req_data",  req_data,        128'(0));
    chk("rst_dma_valid", 128'(dma_valid), 128'(0));
    chk("rst_dma_addr",  128'(dma_addr),  128'(0));
    chk("rst_grant_id",  128'(grant_id),  128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
`ifdef ARB_TIMEOUT_EN
    chk("rst_timeout_err", 128'(timeout_err), 128'(0));
`endif
    rst_n = 1'b1;
    tick(2);

    // Single request from requester 0
    push_grant(1'b0, 32'h100);
    push_ack(2'b01, {16{8'hA5}});
    req_addr[0 +: ADDR_W] = 32'h100;
    req_valid = 2'b01;
    tick(1);
    chk("dma_valid_latency", 128'(dma_valid), 128'(1));
    chk("busy_in_req",       128'(busy),      128'(1));
    serve({16{8'hA5}}, 5, 2'b01);
    tick(1);
    chk("ack_dropped",   128'(req_ack), 128'(0));
    chk("busy_returns0", 128'(busy),    128'(0));

    // Spurious ack in IDLE
    dma_ack  = 1'b1;
    dma_data = 128'hDEAD;
    tick(1);
    dma_ack  = 1'b0;
    dma_data = '0;
    chk("spur_req_ack",   128'(req_ack),   128'(0));
    chk("spur_busy",      128'(busy),      128'(0));
    chk("spur_dma_valid", 128'(dma_valid), 128'(0));
    tick(2);
    chk("spur_req_data",  req_data,        {16{8'hA5}});
    chk("spur_req_ack2",  128'(req_ack),   128'(0));

    // Address hold: requester 1 changes its address after the grant
    push_grant(1'b1, 32'h200);
    push_ack(2'b10, {16{8'h11}});
    req_addr[ADDR_W +: ADDR_W] = 32'h200;
    req_valid = 2'b10;
    tick(1);
    req_addr[ADDR_W +: ADDR_W] = 32'h300;
    tick(3);
    chk("addr_hold", 128'(dma_addr), 128'(32'h200));
    serve({16{8'h11}}, 2, 2'b10);
    tick(1);

    // Contention after reset: grants alternate starting at requester 0
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    push_grant(1'b0, 32'h400); push_ack(2'b01, {4{32'hD0D0_0000}});
    push_grant(1'b1, 32'h500); push_ack(2'b10, {4{32'hD1D1_1111}});
    push_grant(1'b0, 32'h400); push_ack(2'b01, {4{32'hD2D2_2222}});
    push_grant(1'b1, 32'h500); push_ack(2'b10, {4{32'hD3D3_3333}});
    req_addr[0 +: ADDR_W]      = 32'h400;
    req_addr[ADDR_W +: ADDR_W] = 32'h500;
    req_valid = 2'b11;
    serve({4{32'hD0D0_0000}}, 1, 2'b00);
    serve({4{32'hD1D1_1111}}, 3, 2'b00);
    serve({4{32'hD2D2_2222}}, 0, 2'b00);
    serve({4{32'hD3D3_3333}}, 2, 2'b11);
    tick(3);
    chk("contention_idle", 128'(busy), 128'(0));

    // Granted requester withdraws during REQ; ack still delivered
    push_grant(1'b0, 32'h600);
    push_ack(2'b01, {8{16'hBEEF}});
    req_addr[0 +: ADDR_W] = 32'h600;
    req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    serve({8{16'hBEEF}}, 2, 2'b00);
    tick(2);
    chk("withdraw_busy", 128'(busy), 128'(0));

    // Reset mid-transaction, then a late ack after release
    push_grant(1'b1, 32'h700);
    req_addr[ADDR_W +: ADDR_W] = 32'h700;
    req_valid = 2'b10;
    tick(2);
    chk("midrst_pre_valid", 128'(dma_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_dma_valid", 128'(dma_valid), 128'(0));
    chk("midrst_dma_addr",  128'(dma_addr),  128'(0));
    chk("midrst_grant_id",  128'(grant_id),  128'(0));
    chk("midrst_busy",      128'(busy),      128'(0));
    chk("midrst_req_data",  req_data,        128'(0));
    req_valid = 2'b00;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    dma_ack  = 1'b1;
    dma_data = 128'hBAD;
    tick(1);
    dma_ack  = 1'b0;
    dma_data = '0;
    tick(2);
    chk("late_ack_req_ack", 128'(req_ack),   128'(0));
    chk("late_ack_busy",    128'(busy),      128'(0));
    chk("late_ack_data",    req_data,        128'(0));

`ifdef ARB_TIMEOUT_EN
    // Watchdog: ack withheld for 20 REQ cycles
    push_grant(1'b0, 32'h800);
    push_ack(2'b01, {16{8'h5A}});
    req_addr[0 +: ADDR_W] = 32'h800;
    req_valid = 2'b01;
    tick(1);
    tick(15);
    chk("timeout_before", 128'(timeout_err), 128'(0));
    tick(1);
    chk("timeout_rise",   128'(timeout_err), 128'(1));
    tick(3);
    dma_ack  = 1'b1;
    dma_data = {16{8'h5A}};
    tick(1);
    dma_ack  = 1'b0;
    dma_data = '0;
    req_valid = 2'b00;
    tick(2);
    chk("timeout_sticky", 128'(timeout_err), 128'(1));
    chk("timeout_done",   128'(busy),        128'(0));
`endif

    chk("grants_drained", 128'(exp_gid_q.size()), 128'(0));
    chk("acks_drained",   128'(exp_ack_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ic_read_arbiter.md
Name: ic_read_arbiter

Overview:
- Round-robin arbiter sharing one DDR instruction-read port (the valid/addr/ack/data DMA-style interface feeding m_axi4_read_top) between NUM_REQ instruction-cache read requesters, e.g. multiple ic_dram channels.
- One transaction outstanding at a time. The selected address is forwarded downstream, and the returned 128-bit line is routed back with a one-cycle ack to the granted requester only.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, request address width.
- DATA_W, 128, read data width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester read request; level, held high until that requester's req_ack.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ack  out  NUM_REQ  one-cycle pulse to the granted requester when its data is valid.
- req_data  out  DATA_W  registered read data, broadcast to all requesters; qualified by req_ack.
- dma_valid  out  1  downstream read request; held high until dma_ack.
- dma_addr  out  ADDR_W  downstream read address; stable while dma_valid is high.
- dma_ack  in  1  downstream one-cycle data-valid pulse.
- dma_data  in  DATA_W  downstream data, valid with dma_ack.
- grant_id  out  clog2(NUM_REQ) (min 1)  index of the current/last granted requester.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag; present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - req_ack=0, req_data=0.
  - dma_valid=0, dma_addr=0.
  - grant_id=0, busy=0, timeout_err=0.
  - Round-robin pointer set so that requester 0 has highest priority first.
- FSM states IDLE, REQ, DONE:
  - IDLE: if any req_valid is set, pick the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap-around. On that edge, register grant_id=winner, dma_addr=req_addr[winner] and dma_valid=1, then go to REQ. If no req_valid is set, stay in IDLE.
  - REQ: hold dma_valid and dma_addr. On dma_ack, register req_data=dma_data and set req_ack[grant_id]=1 and dma_valid=0 on the same edge, then go to DONE.
  - DONE: exactly one cycle. req_ack is high only here; on exit it returns to 0, last_grant is set to grant_id, and the FSM returns to IDLE.
- Latency:
  - req_valid sampled in IDLE at edge N gives dma_valid high from cycle N+1.
  - dma_ack at edge K gives req_ack and req_data in cycle K+1.
  - Minimum gap between back-to-back grants: 1 IDLE cycle. This lets the acked requester drop req_valid before re-arbitration.
- Boundary conditions:
  - Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0 with no starvation.
  - A requester that is already granted cannot win again while any other requester is valid.
  - dma_ack outside REQ (spurious, or stale after reset): ignored; no req_ack is generated.
  - Granted requester drops req_valid during REQ (protocol violation): the transaction still completes and req_ack is still pulsed; there is no abort path.
  - Changes to req_addr after the grant do not affect dma_addr, which is latched at grant.
  - Reset mid-transaction: all outputs return to reset values immediately. A late dma_ack after release is ignored because the FSM is in IDLE.
  - Requester indices >= NUM_REQ do not exist. grant_id never exceeds NUM_REQ-1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and increments each cycle while in REQ.
  - When the count reaches TIMEOUT_CYC with no dma_ack, timeout_err is set. It is sticky and cleared only by reset.
  - The transaction is not aborted; the FSM keeps waiting for dma_ack.
- Undefined: no counter logic, no timeout_err port; all other behaviour is identical.

Test Plan:
- Single request: req_valid=01, req_addr[0]=0x100; dma_ack 5 cycles after dma_valid with dma_data=0xA5..A5 -> dma_addr=0x100; req_ack=01 for exactly 1 cycle with req_data=0xA5..A5; busy returns to 0.
- Contention, NUM_REQ=2: both requesters valid continuously, each re-requesting after its ack -> grants alternate 0,1,0,1 over 4 transactions; dma_addr alternates between the two addresses.
- Address hold: change req_addr[granted] from 0x200 to 0x300 during REQ -> dma_addr stays 0x200 until dma_ack.
- Spurious ack: pulse dma_ack while in IDLE -> req_ack stays 0, state stays IDLE, req_data unchanged.
- Reset mid-op: assert rst_n=0 during REQ, release, then pulse dma_ack -> dma_valid=0 immediately on reset; the later ack produces no req_ack.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=16: withhold dma_ack for 20 cycles -> timeout_err rises at cycle 16 of REQ and stays high after a later ack completes the transaction normally.
